// File: rtl/gpu_reg_scoreboard_if.sv
// Issue/writeback bus between the issue stage and the register scoreboard.
// The master is the issue stage; the slave is the scoreboard.
interface gpu_reg_scoreboard_if #(
  parameter int unsigned AW = 6,
  parameter int unsigned CW = 3
);

  // Issue-stage instruction fields
  logic          issue_valid;
  logic [AW-1:0] src1;
  logic          src1_used;
  logic [AW-1:0] src2;
  logic          src2_used;
  logic [AW-1:0] dst;
  logic          dst_used;
  logic          long_op;

  // Long-latency writeback retire strobe
  logic          wb_valid;

  // Scoreboard status back to the issue stage and writeback path
  logic          stall;
  logic [AW-1:0] wb_addr;
  logic [CW-1:0] pending_cnt;
  logic          full;
  logic          empty;
  logic          underflow;

  modport master (
    output issue_valid, src1, src1_used, src2, src2_used, dst, dst_used, long_op, wb_valid,
    input  stall, wb_addr, pending_cnt, full, empty, underflow
  );

  modport slave (
    input  issue_valid, src1, src1_used, src2, src2_used, dst, dst_used, long_op, wb_valid,
    output stall, wb_addr, pending_cnt, full, empty, underflow
  );

endinterface

// File: rtl/gpu_reg_scoreboard.sv
// Register scoreboard for the GPU/DSP issue stage.
// Keeps an in-order queue of destination registers with long-latency writes
// outstanding. Issue is held on any RAW/WAW hit against a pending entry, or
// when a long op would allocate into a full queue. Writeback retires the head.
module gpu_reg_scoreboard #(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned AW      = 6
) (
  input  logic                 sys_clk,
  input  logic                 resetl,
  gpu_reg_scoreboard_if.slave  bus
);

  // ENTRIES is a power of two, so pointers wrap naturally at PW bits.
  localparam int unsigned PW = $clog2(ENTRIES);
  localparam int unsigned CW = $clog2(ENTRIES) + 1;

  // Queue storage and bookkeeping
  logic [AW-1:0]      r_addr [ENTRIES];
  logic [ENTRIES-1:0] r_valid;
  logic [PW-1:0]      r_head;
  logic [PW-1:0]      r_tail;
  logic [CW-1:0]      r_cnt;
  logic               r_full;
  logic               r_empty;
  logic               r_underflow;

  // Hazard detection and control
  logic [ENTRIES-1:0] w_match_src1;
  logic [ENTRIES-1:0] w_match_src2;
  logic [ENTRIES-1:0] w_match_dst;
  logic               w_hit_src1;
  logic               w_hit_src2;
  logic               w_hit_dst;
  logic               w_alloc_blocked;
  logic               w_stall;
  logic               w_accept;
  logic               w_alloc;
  logic               w_pop;
  logic [CW-1:0]      w_cnt_next;

  // Per-entry 6-bit equality compare against registered queue state only;
  // a same-cycle pop still hits, giving the one-cycle release latency.
  always_comb begin
    w_match_src1 = '0;
    w_match_src2 = '0;
    w_match_dst  = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      w_match_src1[i] = r_valid[i] && (r_addr[i] == bus.src1);
      w_match_src2[i] = r_valid[i] && (r_addr[i] == bus.src2);
      w_match_dst[i]  = r_valid[i] && (r_addr[i] == bus.dst);
    end
  end

  // Reduce per-entry matches into hazards and derive issue/queue control
  always_comb begin
    w_hit_src1      = bus.src1_used && (|w_match_src1);
    w_hit_src2      = bus.src2_used && (|w_match_src2);
    w_hit_dst       = bus.dst_used  && (|w_match_dst);
    // A pop in the same cycle does not free space for this allocation.
    w_alloc_blocked = bus.long_op && bus.dst_used && r_full;
    w_stall         = bus.issue_valid &&
                      (w_hit_src1 || w_hit_src2 || w_hit_dst || w_alloc_blocked);
    w_accept        = bus.issue_valid && !w_stall;
    w_alloc         = w_accept && bus.long_op && bus.dst_used;
    w_pop           = bus.wb_valid && !r_empty;
  end

  // Occupancy next-state; simultaneous alloc and pop leave it unchanged
  always_comb begin
    w_cnt_next = r_cnt;
    case ({w_alloc, w_pop})
      2'b10:   w_cnt_next = r_cnt + 1'b1;
      2'b01:   w_cnt_next = r_cnt - 1'b1;
      default: w_cnt_next = r_cnt;
    endcase
  end

  // Queue pointers, valid flags and status flags
  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      r_valid     <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_cnt       <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_underflow <= 1'b0;
    end else begin
      // Head and tail can only coincide when empty or full, and then only
      // one of pop/alloc is possible, so these two updates never collide.
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      r_cnt   <= w_cnt_next;
      r_full  <= (w_cnt_next == CW'(ENTRIES));
      r_empty <= (w_cnt_next == '0);
      if (bus.wb_valid && r_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Address storage written at the tail on allocation
  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_addr[i] <= '0;
      end
    end else if (w_alloc) begin
      r_addr[r_tail] <= bus.dst;
    end
  end

  // Outputs; wb_addr is forced to zero when nothing is pending
  assign bus.stall       = w_stall;
  assign bus.wb_addr     = r_empty ? '0 : r_addr[r_head];
  assign bus.pending_cnt = r_cnt;
  assign bus.full        = r_full;
  assign bus.empty       = r_empty;
  assign bus.underflow   = r_underflow;

  // Internal consistency: counter tracks the valid flags, no overflow
  a_cnt_matches_valid: assert property (
    @(posedge sys_clk) disable iff (!resetl)
    r_cnt == CW'($countones(r_valid))
  );

  a_no_alloc_when_full: assert property (
    @(posedge sys_clk) disable iff (!resetl)
    !(w_alloc && r_full)
  );

  a_stall_needs_issue: assert property (
    @(posedge sys_clk) disable iff (!resetl)
    !bus.issue_valid |-> !w_stall
  );

endmodule

// File: tb/tb_gpu_reg_scoreboard.sv
// Self-checking bench for gpu_reg_scoreboard: a vector table for the main
// issue/writeback behaviour, a queue of expected writeback addresses, and
// hand-written reset sequences.
module tb_gpu_reg_scoreboard;

  logic sys_clk;
  logic resetl;

  gpu_reg_scoreboard_if #(.AW(6), .CW(3)) sb_if ();

  gpu_reg_scoreboard #(
    .ENTRIES (4),
    .AW      (6)
  ) u_dut (
    .sys_clk (sys_clk),
    .resetl  (resetl),
    .bus     (sb_if.slave)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       iv;
    logic [5:0] s1;
    logic       s1u;
    logic [5:0] s2;
    logic       s2u;
    logic [5:0] d;
    logic       du;
    logic       lo;
    logic       wb;
    logic       e_stall;
    int         e_cnt;
    logic       e_full;
    logic       e_empty;
    logic       e_uf;
  } vec_t;

  vec_t       vecs[$];
  logic [5:0] exp_q[$];
  int         n_cmp;
  int         n_fail;

  function automatic vec_t mk(logic iv, logic [5:0] s1, logic s1u, logic [5:0] s2, logic s2u,
                              logic [5:0] d, logic du, logic lo, logic wb, logic e_stall,
                              int e_cnt, logic e_full, logic e_empty, logic e_uf);
    vec_t v;
    v.iv = iv; v.s1 = s1; v.s1u = s1u; v.s2 = s2; v.s2u = s2u;
    v.d = d; v.du = du; v.lo = lo; v.wb = wb;
    v.e_stall = e_stall; v.e_cnt = e_cnt; v.e_full = e_full;
    v.e_empty = e_empty; v.e_uf = e_uf;
    return v;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got 0x%0h, expected 0x%0h", name, row, got, exp);
    end
  endtask

  task automatic idle_inputs();
    sb_if.issue_valid = 1'b0;
    sb_if.src1        = 6'h00;
    sb_if.src1_used   = 1'b0;
    sb_if.src2        = 6'h00;
    sb_if.src2_used   = 1'b0;
    sb_if.dst         = 6'h00;
    sb_if.dst_used    = 1'b0;
    sb_if.long_op     = 1'b0;
    sb_if.wb_valid    = 1'b0;
  endtask

  task automatic check_status(input int row, input int e_cnt, input logic e_full,
                              input logic e_empty, input logic e_uf);
    logic [5:0] exp_wb;
    exp_wb = (exp_q.size() > 0) ? exp_q[0] : 6'h00;
    check("pending_cnt", row, 32'(sb_if.pending_cnt), 32'(e_cnt));
    check("full",        row, 32'(sb_if.full),        32'(e_full));
    check("empty",       row, 32'(sb_if.empty),       32'(e_empty));
    check("underflow",   row, 32'(sb_if.underflow),   32'(e_uf));
    check("wb_addr",     row, 32'(sb_if.wb_addr),     32'(exp_wb));
  endtask

  // Drive one vector mid-cycle, check stall before the edge, update the
  // expected-address queue, then check registered status after the edge.
  task automatic step(input vec_t v, input int row);
    @(negedge sys_clk);
    sb_if.issue_valid = v.iv;
    sb_if.src1        = v.s1;
    sb_if.src1_used   = v.s1u;
    sb_if.src2        = v.s2;
    sb_if.src2_used   = v.s2u;
    sb_if.dst         = v.d;
    sb_if.dst_used    = v.du;
    sb_if.long_op     = v.lo;
    sb_if.wb_valid    = v.wb;
    #2;
    check("stall", row, 32'(sb_if.stall), 32'(v.e_stall));
    if (v.wb && exp_q.size() > 0) void'(exp_q.pop_front());
    if (v.iv && !v.e_stall && v.lo && v.du) exp_q.push_back(v.d);
    @(posedge sys_clk);
    #1;
    check_status(row, v.e_cnt, v.e_full, v.e_empty, v.e_uf);
  endtask

  task automatic pulse_reset(input int row);
    @(negedge sys_clk);
    idle_inputs();
    resetl = 1'b0;
    @(posedge sys_clk);
    #1;
    exp_q.delete();
    check_status(row, 0, 1'b0, 1'b1, 1'b0);
    @(negedge sys_clk);
    resetl = 1'b1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    idle_inputs();
    resetl = 1'b0;

    // iv s1 s1u s2 s2u d du lo wb | stall cnt full empty uf
    vecs.push_back(mk(1, 6'h00, 0, 6'h00, 0, 6'h05, 1, 1, 0, 0, 1, 0, 0, 0)); // alloc 05
    vecs.push_back(mk(1, 6'h05, 1, 6'h00, 0, 6'h00, 0, 0, 0, 1, 1, 0, 0, 0)); // RAW src1
    vecs.push_back(mk(1, 6'h25, 1, 6'h00, 0, 6'h00, 0, 0, 0, 0, 1, 0, 0, 0)); // other bank
    vecs.push_back(mk(1, 6'h05, 0, 6'h00, 0, 6'h00, 0, 0, 0, 0, 1, 0, 0, 0)); // src unused
    vecs.push_back(mk(1, 6'h00, 0, 6'h00, 0, 6'h05, 1, 0, 0, 1, 1, 0, 0, 0)); // WAW
    vecs.push_back(mk(1, 6'h00, 0, 6'h05, 1, 6'h00, 0, 0, 1, 1, 0, 0, 1, 0)); // pop+hit
    vecs.push_back(mk(1, 6'h00, 0, 6'h05, 1, 6'h00, 0, 0, 0, 0, 0, 0, 1, 0)); // released
    vecs.push_back(mk(1, 6'h00, 0, 6'h00, 0, 6'h01, 1, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 6'h00, 0, 6'h00, 0, 6'h02, 1, 1, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(1, 6'h00, 0, 6'h00, 0, 6'h03, 1, 1, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(1, 6'h00, 0, 6'h00, 0, 6'h04, 1, 1, 0, 0, 4, 1, 0, 0)); // full
    vecs.push_back(mk(1, 6'h00, 0, 6'h00, 0, 6'h05, 1, 1, 0, 1, 4, 1, 0, 0)); // held
    vecs.push_back(mk(1, 6'h00, 0, 6'h00, 0, 6'h05, 1, 1, 1, 1, 3, 0, 0, 0)); // held+pop
    vecs.push_back(mk(1, 6'h00, 0, 6'h00, 0, 6'h05, 1, 1, 0, 0, 4, 1, 0, 0)); // wraps
    vecs.push_back(mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 0, 0, 1, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 0, 0, 1, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 0, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 0, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 6'h00, 0, 6'h00, 0, 6'h0a, 1, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 6'h00, 0, 6'h00, 0, 6'h0b, 1, 1, 1, 0, 1, 0, 0, 0)); // alloc+pop
    vecs.push_back(mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 0, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 6'h00, 0, 6'h00, 0, 6'h0c, 1, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 6'h0c, 1, 6'h00, 0, 6'h0d, 1, 1, 0, 0, 1, 0, 0, 0)); // no issue
    vecs.push_back(mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 0, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 0, 0, 1, 0, 0, 0, 1, 1)); // underflow
    vecs.push_back(mk(0, 6'h00, 0, 6'h00, 0, 6'h00, 0, 0, 0, 0, 0, 0, 1, 1)); // sticky

    // Reset state
    repeat (2) @(posedge sys_clk);
    #1;
    check_status(-1, 0, 1'b0, 1'b1, 1'b0);
    @(negedge sys_clk);
    resetl = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], i);
    end

    // Reset clears the sticky underflow flag
    pulse_reset(100);

    // Reset mid-operation discards pending entries
    step(mk(1, 6'h00, 0, 6'h00, 0, 6'h11, 1, 1, 0, 0, 1, 0, 0, 0), 200);
    step(mk(1, 6'h00, 0, 6'h00, 0, 6'h12, 1, 1, 0, 0, 2, 0, 0, 0), 201);
    step(mk(1, 6'h00, 0, 6'h00, 0, 6'h13, 1, 1, 0, 0, 3, 0, 0, 0), 202);
    pulse_reset(203);
    step(mk(1, 6'h11, 1, 6'h12, 1, 6'h13, 1, 0, 0, 0, 0, 0, 1, 0), 204);
    step(mk(1, 6'h00, 0, 6'h00, 0, 6'h21, 1, 1, 0, 0, 1, 0, 0, 0), 205);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
